wb_stage: RTL

Write-back stage of the RV32I pipeline: holds the MEM/WB entry, waits for the data-memory load response when needed, aligns and sign/zero-extends load data, and drives the register-file write port (rd address/enable/data). It sits directly upstream of the register file, whose same-cycle write-to-read bypass lets ID read the value being written. It also back-pressures the MEM stage while a load is outstanding and counts retired instructions.

---
 rtl/wb_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// RV32I write-back stage: holds the MEM/WB entry and drives the regfile write port one edge after capture.
// Loads are held in LD_WAIT until the memory response arrives, and o_ready is low only in that state.
module wb_stage #(
   parameter int REGIDX_WIDTH = 5
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [REGIDX_WIDTH-1:0] i_rd_addr,
   input  logic                    i_rd_wen,
   input  logic [1:0]              i_wb_sel,
   input  logic [31:0]             i_alu_result,
   input  logic [31:0]             i_pc_plus4,
   input  logic [2:0]              i_funct3,
   input  logic [1:0]              i_byte_off,
   input  logic                    i_ld_rvalid,
   input  logic [31:0]             i_ld_rdata,
   output logic [REGIDX_WIDTH-1:0] o_rd_addr,
   output logic                    o_rd_wen,
   output logic [31:0]             o_rd_data,
   output logic                    o_ld_err,
   output logic [31:0]             o_retire_cnt
);

   typedef enum logic [1:0] {IDLE = 2'd0, LD_WAIT = 2'd1, LD_WB = 2'd2} state_t;

   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;

   state_t                  state_q, state_d;
   logic                    valid_q, valid_d;
   logic [REGIDX_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                    rd_wen_q, rd_wen_d;
   logic [1:0]              wb_sel_q, wb_sel_d;
   logic [2:0]              funct3_q, funct3_d;
   logic [1:0]              byte_off_q, byte_off_d;
   logic [31:0]             data_q, data_d;
   logic                    ld_err_q, ld_err_d;
   logic [31:0]             retire_q, retire_d;

   logic                    capture;
   logic                    cap_load;
   logic                    wb_cycle;
   logic [7:0]              ld_byte;
   logic [15:0]             ld_half;
   logic [31:0]             ld_aligned;

   // State register and entry flops
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         rd_addr_q  <= '0;
         rd_wen_q   <= 1'b0;
         wb_sel_q   <= 2'b00;
         funct3_q   <= 3'b000;
         byte_off_q <= 2'b00;
         data_q     <= 32'h0;
         ld_err_q   <= 1'b0;
         retire_q   <= 32'h0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         rd_addr_q  <= rd_addr_d;
         rd_wen_q   <= rd_wen_d;
         wb_sel_q   <= wb_sel_d;
         funct3_q   <= funct3_d;
         byte_off_q <= byte_off_d;
         data_q     <= data_d;
         ld_err_q   <= ld_err_d;
         retire_q   <= retire_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (capture) state_d = cap_load ? LD_WAIT : IDLE;
         LD_WAIT: if (i_ld_rvalid) state_d = LD_WB;
         LD_WB:   state_d = (capture && cap_load) ? LD_WAIT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Moore outputs: ready, write-back qualification
   always_comb begin
      o_ready  = (state_q != LD_WAIT);
      wb_cycle = ((state_q == IDLE) && valid_q && (wb_sel_q != WB_LOAD)) ||
                 (state_q == LD_WB);
      o_rd_wen = wb_cycle && valid_q && rd_wen_q && (rd_addr_q != '0);
   end

   assign capture      = i_valid && o_ready;
   assign cap_load     = (i_wb_sel == WB_LOAD);
   assign o_rd_addr    = rd_addr_q;
   assign o_rd_data    = data_q;
   assign o_ld_err     = ld_err_q;
   assign o_retire_cnt = retire_q;

   // Load data alignment, driven from the entry's funct3/byte offset
   always_comb begin
      case (byte_off_q)
         2'd0:    ld_byte = i_ld_rdata[7:0];
         2'd1:    ld_byte = i_ld_rdata[15:8];
         2'd2:    ld_byte = i_ld_rdata[23:16];
         default: ld_byte = i_ld_rdata[31:24];
      endcase
      ld_half = byte_off_q[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
      case (funct3_q)
         3'b000:  ld_aligned = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_aligned = {24'h0, ld_byte};
         3'b001:  ld_aligned = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_aligned = {16'h0, ld_half};
         3'b010:  ld_aligned = i_ld_rdata;
         default: ld_aligned = 32'h0;
      endcase
   end

   // Entry update, retire counter and sticky load error
   always_comb begin
      valid_d    = valid_q;
      rd_addr_d  = rd_addr_q;
      rd_wen_d   = rd_wen_q;
      wb_sel_d   = wb_sel_q;
      funct3_d   = funct3_q;
      byte_off_d = byte_off_q;
      data_d     = data_q;
      if (capture) begin
         valid_d    = 1'b1;
         rd_addr_d  = i_rd_addr;
         rd_wen_d   = i_rd_wen;
         wb_sel_d   = i_wb_sel;
         funct3_d   = i_funct3;
         byte_off_d = i_byte_off;
         data_d     = (i_wb_sel == WB_PC4) ? i_pc_plus4 : i_alu_result;
      end else if (state_q != LD_WAIT) begin
         valid_d = 1'b0;
      end else if (i_ld_rvalid) begin
         data_d = ld_aligned;
      end
      retire_d = (wb_cycle && valid_q) ? retire_q + 32'd1 : retire_q;
      ld_err_d = ld_err_q || (i_ld_rvalid && (state_q != LD_WAIT));
   end

endmodule
